// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares a single-port VRAM between the video fetch engine and the CPU.
// Video always wins: a fetch strobe steers the memory address to the video
// address for that cycle. The CPU gets the memory only on a "free slot"
// (pixel enable high, no fetch, outside the contention window). While it
// waits, the CPU is stalled and the number of pixel ticks spent waiting is
// counted so the last access's stall can be reported.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   ce                    pixel-rate clock enable
//   vRead, vDe, vAddr     video fetch strobe, contention window, fetch address
//   vData                 video fetch data (straight from memDout)
//   cpuReq, cpuWe         CPU request level and write/read select
//   cpuAddr, cpuDin       CPU address and write data
//   cpuDout               CPU read data, registered
//   cpuAck                one-clock completion pulse
//   cpuWait               CPU stall
//   waitCount             pixel ticks the last completed access waited
//   memAddr, memWe, memDin, memDout   VRAM port (asynchronous read)
// ---------------------------------------------------------------------------
module vram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        vRead,
    input  logic        vDe,
    input  logic [12:0] vAddr,
    output logic [7:0]  vData,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [12:0] cpuAddr,
    input  logic [7:0]  cpuDin,
    output logic [7:0]  cpuDout,
    output logic        cpuAck,
    output logic        cpuWait,
    output logic [7:0]  waitCount,
    output logic [12:0] memAddr,
    output logic        memWe,
    output logic [7:0]  memDin,
    input  logic [7:0]  memDout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [12:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  tick_q;
    logic [7:0]  tick_d;
    logic [7:0]  dout_q;
    logic [7:0]  wait_q;
    logic        slotFree;
    logic        grant;

    // A CPU access may only use a pixel-enabled cycle that video neither
    // fetches in nor reserves through its contention window.
    assign slotFree = ce && !vRead && !vDe;
    assign grant    = (state_q == PEND) && slotFree;

    // Stall counter saturates so very long blanking-free stretches read as 255.
    assign tick_d = (tick_q == 8'hFF) ? tick_q : tick_q + 8'd1;

    // Single FSM block: request latch, stall counting, read capture and the
    // report of the stall length when the access completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 13'd0;
            data_q  <= 8'd0;
            tick_q  <= 8'd0;
            dout_q  <= 8'd0;
            wait_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpuReq) begin
                        we_q    <= cpuWe;
                        addr_q  <= cpuAddr;
                        data_q  <= cpuDin;
                        tick_q  <= 8'd0;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (slotFree) begin
                        if (!we_q) begin
                            dout_q <= memDout;
                        end
                        state_q <= ACK;
                    end else if (ce) begin
                        tick_q <= tick_d;
                    end
                end
                ACK: begin
                    // cpuReq is deliberately ignored here; a held request is
                    // picked up again once back in IDLE.
                    wait_q  <= tick_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The memory address defaults to the latched CPU address so a granted
    // access sees a stable address; a video fetch overrides it outright.
    assign memAddr   = vRead ? vAddr : addr_q;
    assign memWe     = grant && we_q;
    assign memDin    = data_q;
    assign vData     = memDout;

    assign cpuDout   = dout_q;
    assign cpuAck    = (state_q == ACK);
    assign cpuWait   = ((state_q == IDLE) && cpuReq) || (state_q == PEND);
    assign waitCount = wait_q;

endmodule
